mem_access_stage: RTL
=====================

# mem_access_stage

Memory-access (M) stage of the 6-stage RISC-V pipeline, directly downstream of execute. It consumes the execute-stage outputs ALUResultX, RD2X and MemWriteX, plus load/control fields. It drives a ready-handshake data-memory port, aligns stores and extends loads, and presents one result per instruction to writeback. It stalls the upstream pipeline while a memory transaction is outstanding and converts misaligned, illegal or timed-out accesses into a fault flag.

## Interface
- MAX_WAIT, 16, maximum BUSY cycles without mem_ready before abort (≥1)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- ValidX  in  1  execute stage holds an instruction
- ALUResultX  in  32  effective address or ALU result
- RD2X  in  32  store data (rs2)
- MemWriteX  in  1  store
- MemReadX  in  1  load
- Funct3X  in  3  access size/sign
- RdX  in  5  destination register
- RegWriteX  in  1  writes rd
- StallM  out  1  upstream must hold X registers
- mem_req  out  1  memory request valid
- mem_we  out  1  write request
- mem_addr  out  32  word address, bits [1:0] = 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned store data
- mem_ready  in  1  access complete this cycle; rdata valid for reads
- mem_rdata  in  32  read word
- ValidM  out  1  one-cycle pulse, result for writeback
- ResultM  out  32  load data or ALU result
- RdM  out  5  destination
- RegWriteM  out  1  write enable, 0 on fault
- FaultM  out  1  misaligned, illegal funct3, or timeout

## Operation
- One-entry op register loads on `ValidX & ~StallM`.
- FSM states:
  - IDLE: no access outstanding.
  - BUSY: mem_req=1, with fields driven from the op register.
- Capture behaviour:
  - Non-memory op: stay IDLE.
  - Legal aligned load/store: IDLE→BUSY.
  - Fault: stay IDLE, no request.
- BUSY→IDLE transitions:
  - On mem_ready=1.
  - Or when the wait counter reaches MAX_WAIT; this is a timeout fault.
- Wait counter: clears on entering BUSY and increments each BUSY cycle without mem_ready.
- Funct3 decode:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 with MemRead/MemWrite is a fault.
- Misalignment: half-word access with addr[0]=1, or word access with addr[1:0]≠0. Misaligned accesses are faults.
- Both MemReadX and MemWriteX set: treat as a store.
- Store alignment:
  - mem_be: SB = 0001<<a[1:0], SH = 0011<<a[1:0], SW = 1111.
  - mem_wdata = RD2 replicated per size (byte ×4, half ×2), so each enabled lane holds the data.
- Load extraction: select the byte/half at a[1:0] from mem_rdata, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- mem_we = stored MemWrite. Stores never set RegWriteM.
- Fault results: ValidM=1, FaultM=1, RegWriteM=0, ResultM = faulting address.
- StallM = `(state==BUSY) & ~mem_ready & ~timeout`. It is combinational, so a new op is accepted on the completing edge.

## Timing
- Reset (async) values:
  - ValidM, RegWriteM, FaultM, mem_req, StallM = 0.
  - ResultM = 0, RdM = 0, state IDLE, counter 0.
- Reset asserted during BUSY: mem_req falls immediately; the pending response is ignored.
- Latency from capture edge to ValidM:
  - Non-memory or fault op: 1 cycle.
  - Memory op: 1 + (BUSY cycles) + 0. Writeback registers update on the edge where mem_ready=1, so ValidM is high in the cycle after mem_ready.
- Back-to-back ops: a new op is captured on the mem_ready edge, and mem_req stays high continuously for a following memory op.
- mem_addr, mem_be, mem_wdata and mem_we are stable for the whole BUSY period.
- mem_ready outside BUSY is ignored.
- Timeout: at MAX_WAIT consecutive BUSY cycles without mem_ready, the next edge returns to IDLE with a fault pulse. A late mem_ready after that is ignored.
- Simultaneous mem_ready and timeout: mem_ready wins (normal completion).

## Test plan
- SW at ALUResultX=0x104, RD2X=0xDEADBEEF, mem_ready immediate → mem_addr 0x104, mem_be 1111, wdata 0xDEADBEEF; ValidM=1, RegWriteM=0.
- SB at 0x103, RD2X=0x000000AB → mem_be 1000, mem_wdata 0xABABABAB, mem_addr 0x100.
- LB then LHU at 0x102 with mem_rdata 0x80FF7F00:
  - LB → ResultM 0xFFFFFFFF.
  - LHU → ResultM 0x000080FF.
  - RdM and RegWriteM=1 are passed through for both.
- LH at 0x101 → no mem_req; the next cycle gives ValidM=1, FaultM=1, RegWriteM=0, ResultM 0x101.
- LW with mem_ready delayed 3 cycles, then an ALU op behind it → StallM high exactly 3 cycles, LW result, then the ALU result in consecutive ValidM pulses.
- Timeout and reset, with MAX_WAIT=4:
  - mem_ready never asserted → fault after 4 BUSY cycles.
  - Separate run: reset asserted mid-BUSY → all outputs return to 0 immediately.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory port of the M stage.
// Ready handshake: request held until mem_ready.
interface mem_access_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr,
    output mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr,
    input  mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage: store alignment, load extension,
// memory handshake with timeout, one result per instruction.
module mem_access_stage #(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ValidX,
  input  logic [31:0] ALUResultX,
  input  logic [31:0] RD2X,
  input  logic        MemWriteX,
  input  logic        MemReadX,
  input  logic [2:0]  Funct3X,
  input  logic [4:0]  RdX,
  input  logic        RegWriteX,
  output logic        StallM,
  mem_access_stage_if.master mem,
  output logic        ValidM,
  output logic [31:0] ResultM,
  output logic [4:0]  RdM,
  output logic        RegWriteM,
  output logic        FaultM
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        rw;
    logic        we;
    logic        fault;
  } op_t;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  op_t           op;
  op_t           nop;
  logic          pend;
  logic          busy;
  logic          timeout;
  logic          done;
  logic          take;
  logic          is_mem;
  logic          bad_f3;
  logic          misal;
  logic          x_fault;
  logic          x_go;
  logic [31:0]   lsh;
  logic [31:0]   ld;

  assign busy    = (state == BUSY);
  assign timeout = busy & (cnt == CW'(MAX_WAIT - 1));
  assign done    = busy & (mem.mem_ready | timeout);
  assign StallM  = busy & ~mem.mem_ready & ~timeout;
  assign take    = ValidX & ~StallM;
  assign is_mem  = MemReadX | MemWriteX;

  always_comb begin
    bad_f3 = 1'b0;
    if (MemWriteX)
      bad_f3 = Funct3X[2] | (&Funct3X[1:0]);
    else if (MemReadX)
      bad_f3 = (&Funct3X[1:0])
             | (Funct3X == 3'b110);
  end

  always_comb begin
    misal = 1'b0;
    case (Funct3X[1:0])
      2'b01:   misal = ALUResultX[0];
      2'b10:   misal = |ALUResultX[1:0];
      default: misal = 1'b0;
    endcase
  end

  assign x_fault = is_mem & (bad_f3 | misal);
  assign x_go    = is_mem & ~x_fault;

  assign nop = '{
    addr:  ALUResultX,
    data:  RD2X,
    f3:    Funct3X,
    rd:    RdX,
    rw:    RegWriteX & ~MemWriteX & ~x_fault,
    we:    MemWriteX,
    fault: x_fault
  };

  assign mem.mem_req  = busy;
  assign mem.mem_we   = busy & op.we;
  assign mem.mem_addr =
    busy ? {op.addr[31:2], 2'b00} : 32'h0;

  always_comb begin
    mem.mem_be    = 4'h0;
    mem.mem_wdata = 32'h0;
    if (busy) begin
      case (op.f3[1:0])
        2'b00: begin
          mem.mem_be    = 4'b0001 << op.addr[1:0];
          mem.mem_wdata = {4{op.data[7:0]}};
        end
        2'b01: begin
          mem.mem_be    = 4'b0011 << op.addr[1:0];
          mem.mem_wdata = {2{op.data[15:0]}};
        end
        default: begin
          mem.mem_be    = 4'hF;
          mem.mem_wdata = op.data;
        end
      endcase
    end
  end

  always_comb begin
    lsh = mem.mem_rdata >> {op.addr[1:0], 3'b000};
    case (op.f3)
      3'b000:  ld = {{24{lsh[7]}}, lsh[7:0]};
      3'b001:  ld = {{16{lsh[15]}}, lsh[15:0]};
      3'b100:  ld = {24'h0, lsh[7:0]};
      3'b101:  ld = {16'h0, lsh[15:0]};
      default: ld = lsh;
    endcase
  end

  // A non-memory op taken while the writeback slot is in
  // use waits one cycle in the op register (pend).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      op        <= '0;
      pend      <= 1'b0;
      ValidM    <= 1'b0;
      ResultM   <= 32'h0;
      RdM       <= 5'h0;
      RegWriteM <= 1'b0;
      FaultM    <= 1'b0;
    end else begin
      ValidM    <= 1'b0;
      RegWriteM <= 1'b0;
      FaultM    <= 1'b0;
      if (done) begin
        ValidM <= 1'b1;
        RdM    <= op.rd;
        if (mem.mem_ready) begin
          ResultM   <= op.we ? op.addr : ld;
          RegWriteM <= op.rw;
        end else begin
          ResultM <= op.addr;
          FaultM  <= 1'b1;
        end
      end else if (pend) begin
        ValidM    <= 1'b1;
        RdM       <= op.rd;
        ResultM   <= op.addr;
        RegWriteM <= op.rw;
        FaultM    <= op.fault;
      end else if (take & ~x_go) begin
        ValidM    <= 1'b1;
        RdM       <= RdX;
        ResultM   <= ALUResultX;
        RegWriteM <= nop.rw;
        FaultM    <= x_fault;
      end

      pend <= 1'b0;
      if (done)
        state <= IDLE;
      if (busy & ~done)
        cnt <= cnt + CW'(1);
      if (take) begin
        if (x_go) begin
          op    <= nop;
          state <= BUSY;
          cnt   <= '0;
        end else if (done | pend) begin
          op   <= nop;
          pend <= 1'b1;
        end
      end
    end
  end

endmodule
